f_pc_unit: RTL

Fetch-stage program-counter unit of the five-stage MIPS pipeline with precise exceptions. Holds the architectural fetch PC, selects the next PC (sequential, branch/jump redirect, ERET return, exception entry) and presents the fetched word to the F/D pipeline register. Also produces the F-stage exception code and branch-delay flag. It sits directly upstream of the F/D register and drives its `instr_F`, `PC_F`, `F_excCode` and `bd_F` inputs.

---
 rtl/f_pc_unit_pkg.sv | 31 +++
 rtl/f_pc_unit_if.sv | 37 +++
 rtl/f_exc_check.sv | 36 +++
 rtl/f_pc_unit.sv | 76 +++++++
 4 files changed

// File: rtl/f_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : f_pc_unit_pkg
//  Purpose  : Shared constants and types for the fetch-stage PC unit.
//             Reset vector, exception entry vector, instruction-memory
//             window and F-stage exception codes.
//  Revision : 1.0 - initial release
// ============================================================================
package f_pc_unit_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_END    = 32'h0000_6FFF;

    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

    localparam logic [31:0] PC_STEP   = 32'd4;

    // Source selected for the next value of the PC register
    typedef enum logic [2:0] {
        NPC_EXC  = 3'd0,
        NPC_HOLD = 3'd1,
        NPC_ERET = 3'd2,
        NPC_JUMP = 3'd3,
        NPC_SEQ  = 3'd4
    } npc_sel_e;

endpackage : f_pc_unit_pkg
`default_nettype wire

// File: rtl/f_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : f_pc_unit_if
//  Purpose   : Bundles the fetch PC unit's control inputs, instruction
//              memory port and F/D register outputs.
//  Modports  : slave  - the PC unit itself
//              master - the surrounding pipeline / memory
//  Revision  : 1.0 - initial release
// ============================================================================
interface f_pc_unit_if;

    logic        req;
    logic        F_en;
    logic        D_jump;
    logic [31:0] D_target;
    logic        D_is_bj;
    logic        D_eret;
    logic [31:0] EPC;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] instr_F;
    logic [31:0] PC_F;
    logic [4:0]  F_excCode;
    logic        bd_F;

    modport slave (
        input  req, F_en, D_jump, D_target, D_is_bj, D_eret, EPC, i_inst_rdata,
        output i_inst_addr, instr_F, PC_F, F_excCode, bd_F
    );

    modport master (
        output req, F_en, D_jump, D_target, D_is_bj, D_eret, EPC, i_inst_rdata,
        input  i_inst_addr, instr_F, PC_F, F_excCode, bd_F
    );

endinterface : f_pc_unit_if
`default_nettype wire

// File: rtl/f_exc_check.sv
`default_nettype none
// ============================================================================
//  Module   : f_exc_check
//  Purpose  : Combinational fetch-address check. Flags AdEL on a misaligned
//             fetch PC and, when F_PC_RANGE_CHECK_EN is defined, on a PC
//             outside the instruction-memory window.
//  Ports    : PC_F      in  32  effective fetch PC
//             F_excCode out  5  EXC_NONE or EXC_ADEL
//  Macro    : F_PC_RANGE_CHECK_EN - enable the address-window check
//  Revision : 1.0 - initial release
// ============================================================================
module f_exc_check
    import f_pc_unit_pkg::*;
(
    input  wire logic [31:0] PC_F,
    output logic      [4:0]  F_excCode
);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned = |PC_F[1:0];

`ifdef F_PC_RANGE_CHECK_EN
    assign w_out_of_range = (PC_F < IM_BASE) || (PC_F > IM_END);
`else
    // Upper address bits are irrelevant when only alignment is checked
    logic w_unused_hi;
    assign w_unused_hi    = ^PC_F[31:2];
    assign w_out_of_range = 1'b0;
`endif

    assign F_excCode = (w_misaligned || w_out_of_range) ? EXC_ADEL : EXC_NONE;

endmodule : f_exc_check
`default_nettype wire

// File: rtl/f_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : f_pc_unit
//  Purpose  : Fetch-stage program counter. Holds the fetch PC, chooses the
//             next PC (sequential, branch/jump, ERET return, exception
//             entry) and presents the fetched word, PC, exception code and
//             branch-delay flag to the F/D register.
//  Ports    : clk   in  system clock
//             reset in  synchronous active-high reset
//             bus   f_pc_unit_if.slave (control inputs, imem port, F outputs)
//  Macro    : F_PC_RANGE_CHECK_EN - adds address-window check to AdEL
//  Revision : 1.0 - initial release
// ============================================================================
module f_pc_unit
    import f_pc_unit_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    f_pc_unit_if.slave  bus
);

    logic [31:0] r_pc_reg;
    logic [31:0] w_pc_f;
    logic [4:0]  w_exc_code;
    npc_sel_e    w_npc_sel;

    // ERET has no delay slot: the return address is fetched in the same
    // cycle the ERET sits in D, without waiting for the register update.
    assign w_pc_f = bus.D_eret ? bus.EPC : r_pc_reg;

    // Next-PC source. An exception request overrides the stall so the
    // handler is entered even while the pipeline is frozen.
    always_comb begin
        w_npc_sel = NPC_SEQ;
        if (bus.req) begin
            w_npc_sel = NPC_EXC;
        end else if (!bus.F_en) begin
            w_npc_sel = NPC_HOLD;
        end else if (bus.D_eret) begin
            w_npc_sel = NPC_ERET;
        end else if (bus.D_jump) begin
            w_npc_sel = NPC_JUMP;
        end else begin
            w_npc_sel = NPC_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_reg <= PC_RESET;
        end else begin
            case (w_npc_sel)
                NPC_EXC:  r_pc_reg <= EXC_ENTRY;
                NPC_HOLD: r_pc_reg <= r_pc_reg;
                NPC_ERET: r_pc_reg <= bus.EPC + PC_STEP;
                NPC_JUMP: r_pc_reg <= bus.D_target;
                default:  r_pc_reg <= w_pc_f + PC_STEP;
            endcase
        end
    end

    f_exc_check u_exc_check (
        .PC_F      (w_pc_f),
        .F_excCode (w_exc_code)
    );

    assign bus.PC_F        = w_pc_f;
    assign bus.i_inst_addr = w_pc_f;
    assign bus.F_excCode   = w_exc_code;
    // A faulting fetch must not let the memory word reach decode
    assign bus.instr_F     = (w_exc_code != EXC_NONE) ? 32'h0 : bus.i_inst_rdata;
    // The instruction after ERET is not a delay slot
    assign bus.bd_F        = bus.D_is_bj & ~bus.D_eret;

endmodule : f_pc_unit
`default_nettype wire
